// File: rtl/read_pixel.sv
// Single-pixel frame-buffer reader: validates coordinates, issues one linear read,
// waits out the memory latency and returns the RGB565 word with a one-cycle strobe.
module read_pixel #(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 320,
  parameter int READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic        pixelRead,
  output logic        pixelReady,
  output logic [15:0] pixelData,
  output logic        pixelValid,
  output logic        pixelError,
  output logic [16:0] memAddr,
  output logic        memRead,
  input  logic [15:0] memData
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} stateT;

  localparam logic [2:0]  LAST_WAIT = 3'(READ_LATENCY - 1);
  localparam logic [16:0] WIDTH17   = 17'(WIDTH);

  stateT       stateReg, stateNext;
  logic        armedReg;
  logic [2:0]  waitCntReg;
  logic [15:0] pixelDataReg;
  logic        pixelErrorReg;
  logic [16:0] memAddrReg;

  logic        accept;
  logic        inRange;
  logic        waitDone;
  logic [16:0] linearAddr;

  assign inRange    = (32'(xAddr) < WIDTH) && (32'(yAddr) < HEIGHT);
  assign linearAddr = 17'(yAddr) * WIDTH17 + 17'(xAddr);
  assign accept     = pixelRead && pixelReady;
  assign waitDone   = (stateReg == WAIT) && (waitCntReg == LAST_WAIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (accept) stateNext = inRange ? ADDR : DONE;
      ADDR: stateNext = WAIT;
      WAIT: if (waitDone) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // armedReg keeps pixelReady low during reset and raises it on the first edge after release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armedReg      <= 1'b0;
      waitCntReg    <= 3'd0;
      pixelDataReg  <= 16'h0000;
      pixelErrorReg <= 1'b0;
      memAddrReg    <= 17'd0;
    end else begin
      armedReg <= 1'b1;
      if ((stateReg == WAIT) && !waitDone) begin
        waitCntReg <= waitCntReg + 3'd1;
      end else begin
        waitCntReg <= 3'd0;
      end
      if (accept && inRange) begin
        memAddrReg <= linearAddr;
      end
      // Result registers only change on the edge entering DONE, so they stay stable between strobes.
      if (accept && !inRange) begin
        pixelDataReg  <= 16'h0000;
        pixelErrorReg <= 1'b1;
      end else if (waitDone) begin
        pixelDataReg  <= memData;
        pixelErrorReg <= 1'b0;
      end
    end
  end

  always_comb begin
    pixelReady = (stateReg == IDLE) && armedReg;
    memRead    = (stateReg == ADDR);
    pixelValid = (stateReg == DONE);
    pixelData  = pixelDataReg;
    pixelError = pixelErrorReg;
    memAddr    = memAddrReg;
  end

endmodule

// File: doc/read_pixel.md
READ_PIXEL -- requirements
Module: read_pixel

Interface
REQ-001 SHALL have parameter WIDTH, default 240, display width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 320, display height in pixels.
REQ-003 SHALL have parameter READ_LATENCY, default 2, frame-buffer read latency in clocks, legal range 1..8.
REQ-004 SHALL have one clock and asynchronous, active-high reset: clock  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have xAddr  input  8  pixel column.
REQ-007 SHALL have yAddr  input  9  pixel row.
REQ-008 SHALL have pixelRead  input  1  read request.
REQ-009 SHALL have pixelReady  output  1  block idle, request will be accepted.
REQ-010 SHALL have pixelData  output  16  RGB565 pixel read back.
REQ-011 SHALL have pixelValid  output  1  one-cycle strobe, pixelData/pixelError valid.
REQ-012 SHALL have pixelError  output  1  coordinates were out of range.
REQ-013 SHALL have memAddr  output  17  linear frame-buffer address.
REQ-014 SHALL have memRead  output  1  one-cycle frame-buffer read strobe.
REQ-015 SHALL have memData  input  16  frame-buffer read data.

Function
REQ-016 SHALL implement states IDLE, ADDR, WAIT, DONE; pixelReady = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge where pixelRead && pixelReady, latching xAddr/yAddr; input changes after acceptance ignored.
REQ-018 SHALL ignore pixelRead while pixelReady = 0 (no queuing).
REQ-019 SHALL on acceptance go IDLE->ADDR if xAddr < WIDTH and yAddr < HEIGHT, else IDLE->DONE with error flagged.
REQ-020 SHALL in ADDR drive memAddr = yAddr*WIDTH + xAddr (17-bit, unsigned) and memRead = 1 for exactly one cycle, then go to WAIT.
REQ-021 SHALL in WAIT count READ_LATENCY cycles from the edge sampling memRead, capture memData into pixelData on the final edge, then go to DONE.
REQ-022 SHALL in DONE assert pixelValid for exactly one cycle, then go to IDLE; pixelReady reasserts the cycle after pixelValid.
REQ-023 SHALL assert pixelValid READ_LATENCY+1 cycles after the accepting edge for in-range reads; one cycle after for out-of-range.
REQ-024 SHALL for out-of-range requests never assert memRead, set pixelData = 16'h0000, pixelError = 1.
REQ-025 SHALL for in-range requests set pixelError = 0.
REQ-026 SHALL hold pixelData and pixelError stable between pixelValid strobes.
REQ-027 SHALL hold memAddr at its last value when memRead = 0.
REQ-028 SHALL with pixelRead held high continuously serve back-to-back requests, one per READ_LATENCY+3 cycles.

Reset
REQ-029 SHALL while reset = 1 force state IDLE, pixelReady = 0, pixelValid = 0, pixelError = 0, pixelData = 0, memRead = 0, memAddr = 0.
REQ-030 SHALL assert pixelReady on the first rising edge after reset deasserts.
REQ-031 SHALL on reset mid-operation abandon the request; no pixelValid for it; late memData ignored.

Verification
REQ-032 SHALL cover: L=2, read (0,0), memData=16'hF800 -> memAddr=0, memRead one cycle, pixelValid 3 cycles after accept, pixelData=F800, pixelError=0.
REQ-033 SHALL cover: read (239,319) -> memAddr=76799; read (17,5) -> memAddr=1217.
REQ-034 SHALL cover: read (240,0) and (0,320) -> no memRead, pixelValid 1 cycle after accept, pixelError=1, pixelData=0.
REQ-035 SHALL cover: reset asserted in WAIT -> all outputs zero, no pixelValid, pixelReady 1 edge after release.
REQ-036 SHALL cover: pixelRead held high, L=1 and L=8 -> requests spaced 4 and 11 cycles, each pixelValid exactly one cycle.
REQ-037 SHALL cover: xAddr changed during WAIT and pixelRead pulsed while busy -> result unaffected, no extra request.
